bus_master_if: RTL
==================

Name: bus_master_if

Overview:
- Bus initiator that converts single-word read/write requests from a CPU pipeline stage into bus transactions.
- Bus protocol per transaction: request/grant arbitration (bus_req_, bus_grant_), one-cycle address strobe (bus_as_), then wait for the slave ready (bus_rdy_).
- Serves as the opposite end of the memory-mapped slaves (ROM, SPM, peripherals), which register rdy_ one cycle after seeing their select and as_ together.
- Stalls the pipeline for the whole transaction and returns registered read data.

Parameters:
- ADDR_W, 30, word-address width.
- DATA_W, 32, data word width.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before an error completion; used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  transaction request; held high until the cpu_done cycle.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_addr  in  ADDR_W  word address.
- cpu_wr_data  in  DATA_W  write data.
- cpu_flush  in  1  pipeline flush; cancels a not-yet-started transaction.
- cpu_rd_data  out  DATA_W  read data, valid in the cpu_done cycle and held afterwards.
- cpu_stall  out  1  pipeline stall.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  completion was a timeout (always 0 without BUS_TIMEOUT_EN).
- bus_req_  out  1  active-low arbitration request.
- bus_grant_  in  1  active-low grant.
- bus_as_  out  1  active-low address strobe.
- bus_rw  out  1  1 = read, 0 = write.
- bus_addr  out  ADDR_W  bus address.
- bus_wr_data  out  DATA_W  bus write data.
- bus_rd_data  in  DATA_W  slave read data, valid when bus_rdy_ = 0.
- bus_rdy_  in  1  active-low slave ready.

Behaviour:
- Reset (asynchronous, reset = 0):
  - state = IDLE.
  - bus_req_ = 1, bus_as_ = 1, bus_rw = 1.
  - bus_addr, bus_wr_data, cpu_rd_data = 0.
  - cpu_done = 0, cpu_err = 0.
  - Reset taking effect mid-transaction abandons it immediately; the slave sees as_ released.
- All bus_* outputs, cpu_rd_data, cpu_done and cpu_err are registered.
- cpu_stall is combinational: cpu_stall = cpu_req & (state != DONE) & ~cpu_flush.
- IDLE:
  - If cpu_req = 1 and cpu_flush = 0: bus_req_ <= 0, latch cpu_rw/cpu_addr/cpu_wr_data into bus_rw/bus_addr/bus_wr_data, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - cpu_flush = 1 -> bus_req_ <= 1, go to IDLE (no bus activity).
  - Else if bus_grant_ = 0 -> bus_as_ <= 0, go to ACCESS.
  - Else stay in REQ.
- ACCESS (bus_as_ = 0 for exactly this one cycle):
  - bus_as_ <= 1 on exit.
  - bus_rdy_ = 0 -> go to DONE; this covers combinational slaves.
  - Otherwise go to WAIT.
- WAIT:
  - Stay until bus_rdy_ = 0, then go to DONE.
  - On completion, a read captures cpu_rd_data <= bus_rd_data.
  - Address, rw and write data are held stable through ACCESS and WAIT.
- DONE:
  - cpu_done = 1, bus_req_ <= 1, go to IDLE.
  - Exactly one bubble between back-to-back transactions.
- cpu_flush in ACCESS or WAIT:
  - The bus transaction still completes; it cannot be aborted.
  - On completion, cpu_done stays 0 and cpu_rd_data is not updated (a sticky "flushed" flag marks this).
- Minimum read latency against a registered-rdy_ slave with immediate grant:
  - req in cycle 0; REQ in cycle 1; ACCESS in cycle 2; WAIT (rdy_ low) in cycle 3; DONE in cycle 4.
  - Result: 4 cycles of stall, cpu_done in cycle 4.
- Writes follow the same sequence; cpu_rd_data is unchanged.
- bus_rdy_ is ignored in IDLE, REQ and DONE.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro defined:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES with bus_rdy_ still 1: go to DONE with cpu_err = 1 and cpu_rd_data = 0.
  - cpu_err clears on the next transaction start.
  - bus_rdy_ = 0 in the same cycle as expiry takes priority: normal completion, cpu_err = 0.
- Without the macro: WAIT lasts indefinitely, cpu_err is constant 0, and no counter is present.

Test Plan:
- Read, grant and registered-rdy_ immediate: addr 0x0000_0010, bus_rd_data 0xDEAD_BEEF -> bus_as_ low only in cycle 2; cpu_done in cycle 4 with cpu_rd_data 0xDEAD_BEEF; cpu_stall high for cycles 0-3.
- Grant delayed 3 cycles: bus_req_ held low and bus_as_ stays 1 until the grant; total latency 7 cycles; address stable throughout.
- Write 0x1234_5678 to addr 0x5, rdy_ after 2 wait cycles -> bus_rw = 0 and bus_wr_data stable from ACCESS to DONE; cpu_rd_data unchanged.
- cpu_flush in REQ -> bus_req_ returns to 1 next cycle with no as_ pulse and no cpu_done. cpu_flush in WAIT -> transaction completes on the bus, cpu_done stays 0, cpu_rd_data unchanged.
- reset driven low while in WAIT -> bus_as_ and bus_req_ go to 1 and state goes to IDLE without a clock edge; next request completes normally.
- BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4, bus_rdy_ never low -> cpu_done with cpu_err = 1 and cpu_rd_data = 0 after 4 WAIT cycles. Same case with rdy_ low exactly at expiry -> cpu_err = 0 and data captured.

Source files
------------

// File: rtl/bus_master_if_if.sv
// ---------------------------------------------------------------------------
// bus_master_if_if
//
// Signal bundle for the shared system bus between one initiator and the
// memory-mapped slaves (ROM, SPM, peripherals). All handshake strobes are
// active-low, marked by a trailing underscore.
//
// Signals:
//   bus_req_     initiator -> arbiter   arbitration request
//   bus_grant_   arbiter   -> initiator bus grant
//   bus_as_      initiator -> slaves    one-cycle address strobe
//   bus_rw       initiator -> slaves    1 = read, 0 = write
//   bus_addr     initiator -> slaves    word address (ADDR_W)
//   bus_wr_data  initiator -> slaves    write data (DATA_W)
//   bus_rd_data  slaves    -> initiator read data, valid while bus_rdy_ = 0
//   bus_rdy_     slaves    -> initiator transfer complete
//
// Modports:
//   master  the initiator side (bus_master_if)
//   slave   the responder side (grant driven by the arbiter or the bench)
// ---------------------------------------------------------------------------
interface bus_master_if_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);

  logic              bus_req_;
  logic              bus_grant_;
  logic              bus_as_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  modport master (
    output bus_req_,
    output bus_as_,
    output bus_rw,
    output bus_addr,
    output bus_wr_data,
    input  bus_grant_,
    input  bus_rd_data,
    input  bus_rdy_
  );

  modport slave (
    input  bus_req_,
    input  bus_as_,
    input  bus_rw,
    input  bus_addr,
    input  bus_wr_data,
    output bus_grant_,
    output bus_rd_data,
    output bus_rdy_
  );

endinterface

// File: rtl/bus_master_if.sv
// ---------------------------------------------------------------------------
// bus_master_if
//
// Bus initiator that turns single-word read/write requests from a CPU
// pipeline stage into bus transactions:
//   request/grant arbitration -> one-cycle address strobe -> wait for ready.
// The pipeline is stalled for the whole transaction; read data comes back
// registered together with a one-cycle cpu_done pulse.
//
// Sequence against a registered-ready slave with immediate grant:
//   cycle 0 IDLE (cpu_req seen), 1 REQ, 2 ACCESS (as_ low),
//   3 WAIT (rdy_ low), 4 DONE (cpu_done, cpu_rd_data valid).
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   cpu_req      request, held high until the cpu_done cycle
//   cpu_rw       1 = read, 0 = write
//   cpu_addr     word address
//   cpu_wr_data  write data
//   cpu_flush    pipeline flush; cancels a transaction still in REQ
//   cpu_rd_data  registered read data, valid in the cpu_done cycle and held
//   cpu_stall    combinational pipeline stall
//   cpu_done     one-cycle completion pulse
//   cpu_err      completion was a bus timeout
//   bus          bus_master_if_if.master bundle (see rtl/bus_master_if_if.sv)
//
// Optional feature (macro BUS_TIMEOUT_EN):
//   When defined, a WAIT-cycle counter forces an error completion
//   (cpu_err = 1, cpu_rd_data = 0) after TIMEOUT_CYCLES cycles in WAIT with
//   no ready. When undefined, WAIT lasts indefinitely and cpu_err is 0.
// ---------------------------------------------------------------------------
module bus_master_if #(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic              cpu_flush,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_stall,
  output logic              cpu_done,
  output logic              cpu_err,
  bus_master_if_if.master   bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    ACCESS = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;

  logic              req_n_q, req_n_d;
  logic              as_n_q, as_n_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  // Set when the pipeline flushed after the bus transaction had already
  // started; the transaction finishes on the bus but is not reported.
  logic              flushed_q, flushed_d;

  logic              start;
  logic              complete;
  logic              flush_late;
  logic              timeout_hit;

  assign start      = (state_q == IDLE) && cpu_req && !cpu_flush;
  assign flush_late = cpu_flush && ((state_q == ACCESS) || (state_q == WAIT));
  // DONE is only ever entered from ACCESS or WAIT.
  assign complete   = (state_d == DONE) && (state_q != DONE);

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q;

  // The counter sits at zero outside WAIT, so it is clear on WAIT entry and
  // equals the number of WAIT cycles already spent. Ready in the expiry
  // cycle wins because the hit requires bus_rdy_ still high.
  assign timeout_hit = (state_q == WAIT) && bus.bus_rdy_ &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d = '0;
    if (state_q == WAIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (start) begin
        err_q <= 1'b0;
      end else if (complete && !flushed_d && timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign cpu_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign cpu_err     = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_n_q   <= 1'b1;
      as_n_q    <= 1'b1;
      rw_q      <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_n_q   <= req_n_d;
      as_n_q    <= as_n_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      flushed_q <= flushed_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_req && !cpu_flush) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (cpu_flush) begin
          state_d = IDLE;
        end else if (!bus.bus_grant_) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // A combinational slave can answer in the strobe cycle itself.
        if (!bus.bus_rdy_) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!bus.bus_rdy_ || timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    req_n_d   = req_n_q;
    as_n_d    = as_n_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    flushed_d = flushed_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          req_n_d   = 1'b0;
          rw_d      = cpu_rw;
          addr_d    = cpu_addr;
          wdata_d   = cpu_wr_data;
          flushed_d = 1'b0;
        end
      end
      REQ: begin
        if (cpu_flush) begin
          req_n_d = 1'b1;
        end else if (!bus.bus_grant_) begin
          as_n_d = 1'b0;
        end
      end
      ACCESS: begin
        as_n_d = 1'b1;
      end
      DONE: begin
        req_n_d = 1'b1;
      end
      default: begin
      end
    endcase

    if (flush_late) begin
      flushed_d = 1'b1;
    end

    // A flushed transaction completes silently: no pulse, data untouched.
    if (complete && !flushed_d) begin
      done_d = 1'b1;
      if (timeout_hit) begin
        rdata_d = '0;
      end else if (rw_q) begin
        rdata_d = bus.bus_rd_data;
      end
    end
  end

  assign cpu_stall = cpu_req && (state_q != DONE) && !cpu_flush;

  assign cpu_rd_data     = rdata_q;
  assign cpu_done        = done_q;
  assign bus.bus_req_    = req_n_q;
  assign bus.bus_as_     = as_n_q;
  assign bus.bus_rw      = rw_q;
  assign bus.bus_addr    = addr_q;
  assign bus.bus_wr_data = wdata_q;

endmodule
